lane_gather_4to1: RTL

- Sequential, in-order reassembler for 16-bit words that were scattered round-robin across 4 parallel processing lanes, e.g. the per-lane outputs of the pixel/MAC datapath.
- Gathers the lane results back into one valid/ready stream in original order: lane 0, 1, 2, 3, 0, ...
- Tags the last word of each frame.
- Sits between the lane array and the result buffer / Avalon-facing logic.

---
 rtl/lane_gather_4to1.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/lane_gather_4to1.sv
`default_nettype none
// ============================================================================
//  Module      : lane_gather_4to1
//  Description : In-order reassembler for words scattered round-robin across
//                four lanes. Each lane feeds a small FIFO; the lanes are drained
//                strictly in turn (0,1,2,3,0,...) into one valid/ready output
//                register, with the last word of each frame tagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_gather_4to1 #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 2,
    parameter int FRAME_LEN = 784
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [3:0]            in_valid,
    input  logic [4*DATA_W-1:0]   in_data,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic [1:0]            sel_lane
);

    localparam int                 c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(DEPTH);
    localparam logic [15:0]        c_LAST_IDX = 16'(FRAME_LEN - 1);

    // Reset and flush have identical effect, so they share one clear term.
    logic                w_clear;
    logic [3:0]          w_full;
    logic [3:0]          w_nonempty;
    logic [3:0]          w_push;
    logic [3:0]          w_pop;
    logic [DATA_W-1:0]   w_head [4];
    logic                w_load;
    logic                w_xfer;
    logic                w_is_last;

    logic [1:0]          r_sel;
    logic [15:0]         r_word_cnt;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic                r_frame_done;

    assign w_clear   = reset | flush;
    assign w_load    = w_nonempty[r_sel] && (!r_out_valid || out_ready);
    assign w_xfer    = r_out_valid && out_ready;
    assign w_is_last = (r_word_cnt == c_LAST_IDX);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [DATA_W-1:0]  r_mem [DEPTH];
        logic [c_PTR_W-1:0] r_wptr;
        logic [c_PTR_W-1:0] r_rptr;
        logic [c_PTR_W:0]   r_count;

        // Ready depends on stored occupancy only, so a full FIFO refuses a
        // push even when the same cycle pops it.
        assign w_full[gi]     = (r_count == c_CNT_FULL);
        assign w_nonempty[gi] = (r_count != '0);
        assign w_push[gi]     = in_valid[gi] && !w_full[gi] && !w_clear;
        assign w_pop[gi]      = w_load && (r_sel == 2'(gi));
        assign w_head[gi]     = r_mem[r_rptr];
        assign in_ready[gi]   = !w_full[gi];

        // Storage array: written on push, contents need no clear.
        always_ff @(posedge clk) begin
            if (w_push[gi]) begin
                r_mem[r_wptr] <= in_data[gi*DATA_W +: DATA_W];
            end
        end

        // Pointer and occupancy bookkeeping for this lane.
        always_ff @(posedge clk) begin
            if (w_clear) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push[gi]) begin
                    r_wptr <= r_wptr + c_PTR_ONE;
                end
                if (w_pop[gi]) begin
                    r_rptr <= r_rptr + c_PTR_ONE;
                end
                case ({w_push[gi], w_pop[gi]})
                    2'b10:   r_count <= r_count + c_CNT_ONE;
                    2'b01:   r_count <= r_count - c_CNT_ONE;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Output register with lane sequencing; a load replaces a word that is
    // transferring in the same cycle, so there is no bubble.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_sel       <= 2'd0;
            r_word_cnt  <= 16'd0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head[r_sel];
            r_out_last  <= w_is_last;
            if (w_is_last) begin
                r_sel      <= 2'd0;
                r_word_cnt <= 16'd0;
            end else begin
                r_sel      <= r_sel + 2'd1;
                r_word_cnt <= r_word_cnt + 16'd1;
            end
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    // One-cycle pulse after the frame-last word leaves the output register.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer && r_out_last;
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign frame_done = r_frame_done;
    assign sel_lane   = r_sel;

endmodule
`default_nettype wire
